// File: rtl/wishbone_ctl_mc.sv
// Multi-channel Wishbone slave controller. A Caravel-style 32-bit slave port is
// decoded into NUM_CH equal address windows. Each access is forwarded to one
// backend channel with a req/ack handshake and an optional timeout.
module wishbone_ctl_mc #(
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int          NUM_CH        = 4,
    parameter int          CH_SPAN_LOG2  = 8,
    parameter int          OPCODE_OFFSET = 0,
    parameter int          TIMEOUT       = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_dat_i,
    input  logic [31:0]               wbs_adr_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    output logic [NUM_CH-1:0]         ch_req_o,
    output logic                      ch_we_o,
    output logic [CH_SPAN_LOG2-1:0]   ch_addr_o,
    output logic [31:0]               ch_wdata_o,
    output logic [3:0]                ch_wmask_o,
    output logic [NUM_CH-1:0]         ch_config_en_o,
    input  logic [NUM_CH-1:0]         ch_ack_i,
    input  logic [32*NUM_CH-1:0]      ch_rdata_i,
    output logic                      timeout_o
);

    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // Counter is kept at least one bit wide so TIMEOUT=0 still elaborates.
    localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    // 33-bit bounds so a window ending at 2^32 cannot wrap to a small address.
    localparam logic [32:0] BASE33  = {1'b0, BASE_ADDR};
    localparam logic [32:0] LIMIT33 = BASE33 + (33'(NUM_CH) << CH_SPAN_LOG2);
    localparam logic [CH_SPAN_LOG2-1:0] OPC_OFF = CH_SPAN_LOG2'(OPCODE_OFFSET);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t                  state, state_d;
    logic [CW-1:0]           cnt, cnt_d;
    logic [CHW-1:0]          idx_q;
    logic                    req, hit, latch;
    logic [31:0]             rel;
    logic [CHW-1:0]          idx_in;
    logic [CH_SPAN_LOG2-1:0] off_in;
    logic [NUM_CH-1:0]       oh_in;
    logic                    ack_sel;
    logic [31:0]             rdata_sel;
    logic [NUM_CH-1:0]       req_d, cfg_d;
    logic                    ack_d, tmo_d;
    logic [31:0]             dat_d;

    assign req       = wbs_stb_i & wbs_cyc_i;
    assign hit       = ({1'b0, wbs_adr_i} >= BASE33) && ({1'b0, wbs_adr_i} < LIMIT33);
    assign rel       = wbs_adr_i - BASE_ADDR;
    assign idx_in    = CHW'(rel >> CH_SPAN_LOG2);
    assign off_in    = wbs_adr_i[CH_SPAN_LOG2-1:0];
    assign ack_sel   = ch_ack_i[idx_q];
    assign rdata_sel = ch_rdata_i[32*idx_q +: 32];

    // One-hot select of the channel addressed by the incoming request.
    always_comb begin
        oh_in         = '0;
        oh_in[idx_in] = 1'b1;
    end

    // Next-state and next registered-output logic for the transfer FSM.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        req_d   = ch_req_o;
        cfg_d   = ch_config_en_o;
        ack_d   = 1'b0;
        tmo_d   = 1'b0;
        dat_d   = '0;
        latch   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    latch = 1'b1;
                    if (hit) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                        req_d   = oh_in;
                        cfg_d   = (wbs_we_i && off_in == OPC_OFF) ? oh_in : '0;
                    end else begin
                        // Miss: complete immediately with zero data, write dropped.
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt + 1'b1;
                if (!wbs_cyc_i) begin
                    // Master abort beats a same-cycle backend ack.
                    state_d = S_IDLE;
                    req_d   = '0;
                    cfg_d   = '0;
                end else if (ack_sel) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    dat_d   = ch_we_o ? 32'h0 : rdata_sel;
                    req_d   = '0;
                    cfg_d   = '0;
                end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    tmo_d   = 1'b1;
                    req_d   = '0;
                    cfg_d   = '0;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = '0;
                cfg_d   = '0;
            end
        endcase
    end

    // State, counter and handshake outputs; reset discards any in-flight transfer.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state          <= S_IDLE;
            cnt            <= '0;
            ch_req_o       <= '0;
            ch_config_en_o <= '0;
            wbs_ack_o      <= 1'b0;
            wbs_dat_o      <= '0;
            timeout_o      <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            ch_req_o       <= req_d;
            ch_config_en_o <= cfg_d;
            wbs_ack_o      <= ack_d;
            wbs_dat_o      <= dat_d;
            timeout_o      <= tmo_d;
        end
    end

    // Request fields captured on acceptance and held until the next accepted request.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            idx_q      <= '0;
            ch_we_o    <= 1'b0;
            ch_addr_o  <= '0;
            ch_wdata_o <= '0;
            ch_wmask_o <= '0;
        end else if (latch) begin
            idx_q      <= idx_in;
            ch_we_o    <= wbs_we_i;
            ch_addr_o  <= off_in;
            ch_wdata_o <= wbs_dat_i;
            ch_wmask_o <= wbs_we_i ? wbs_sel_i : 4'h0;
        end
    end

endmodule

// File: doc/wishbone_ctl_mc.md
# wishbone_ctl_mc

Multi-channel Wishbone slave controller: decodes a Caravel-style 32-bit Wishbone slave port into `NUM_CH` equal address windows and forwards each access to one backend channel. It uses a request/acknowledge handshake with wait states, byte-lane masks, and a timeout. It sits between the management SoC bus and the accelerator's per-channel register/SRAM blocks. It is the successor to the single-channel controller, which always acknowledged in one cycle and had one config window.

## Interface
- `BASE_ADDR`, 32'h3000_0000, byte address of channel 0 window.
- `NUM_CH`, 4, number of backend channels (1..16).
- `CH_SPAN_LOG2`, 8, log2 of each window's size in bytes (4..20).
- `OPCODE_OFFSET`, 0, byte offset within a window that raises that channel's config enable.
- `TIMEOUT`, 255, maximum backend wait cycles before forced completion; 0 disables the timeout.

Ports:
- `wb_clk_i`  in  1  the block's single clock.
- `wb_rst_i`  in  1  reset, asynchronous and active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone strobe, cycle and write-enable.
- `wbs_sel_i`  in  4  byte selects.
- `wbs_dat_i`  in  32  write data.
- `wbs_adr_i`  in  32  byte address.
- `wbs_ack_o`  out  1  Wishbone acknowledge, a registered single-cycle pulse.
- `wbs_dat_o`  out  32  read data, registered and valid while `wbs_ack_o`=1.
- `ch_req_o`  out  NUM_CH  one-hot request to the selected channel.
- `ch_we_o`  out  1  latched write-enable.
- `ch_addr_o`  out  CH_SPAN_LOG2  latched byte offset within the window.
- `ch_wdata_o`  out  32  latched write data.
- `ch_wmask_o`  out  4  latched `wbs_sel_i` on writes; 4'h0 on reads.
- `ch_config_en_o`  out  NUM_CH  one-hot; high together with `ch_req_o` for writes at `OPCODE_OFFSET`.
- `ch_ack_i`  in  NUM_CH  per-channel completion.
- `ch_rdata_i`  in  32*NUM_CH  per-channel read data; channel k occupies bits [32k+31:32k].
- `timeout_o`  out  1  single-cycle pulse when a transfer times out.

## Operation
- Request: `req = wbs_stb_i & wbs_cyc_i`.
- Address hit: `BASE_ADDR <= adr < BASE_ADDR + (NUM_CH << CH_SPAN_LOG2)`, compared on 33-bit arithmetic so the window cannot wrap past 2^32.
- Channel index: `idx = (adr - BASE_ADDR) >> CH_SPAN_LOG2`.
- Offset: `adr[CH_SPAN_LOG2-1:0]`.
- States: IDLE, WAIT, ACK.
- IDLE:
  - On `req`, latch we, address, data and sel.
  - On a hit, go to WAIT. `ch_req_o[idx]` and, if applicable, `ch_config_en_o[idx]` go high next cycle.
  - On a miss, go to ACK with read data 0. Miss writes are dropped.
- WAIT:
  - `ch_req_o[idx]` held high; wait counter increments each cycle.
  - `ch_ack_i[idx]`=1: capture `ch_rdata_i[idx]` (reads only; writes return 0), go to ACK.
  - Counter reaches TIMEOUT (nonzero TIMEOUT): go to ACK with read data 0, pulse `timeout_o`.
  - Acks on other channels are ignored.
  - `wbs_cyc_i`=0 (abort): return to IDLE, drop `ch_req_o`, no `wbs_ack_o`.
  - Abort and ack in the same cycle: abort wins.
- ACK:
  - `wbs_ack_o`=1 for exactly one cycle, then IDLE.
  - A new `req` is accepted only in IDLE. No back-to-back acks: at most one ack per 2 cycles.
- Wait counter: width $clog2(TIMEOUT+1); cleared on entry to WAIT.
- Reset, asynchronous at any time including mid-transfer:
  - State returns to IDLE.
  - All outputs 0, including `wbs_dat_o`, `ch_*_o` and `timeout_o`.
  - In-flight transfer discarded, never acknowledged.

## Timing
- Edge 0: IDLE samples `req`.
- Hit: `ch_req_o` high in cycle 1.
- Backend ack sampled at edge n≥2: `wbs_ack_o` high in cycle n. Minimum latency is 2 cycles, with a combinational backend ack in cycle 1.
- Miss: `wbs_ack_o` high in cycle 1.
- Timeout: `ch_req_o` high for TIMEOUT cycles; `wbs_ack_o` and `timeout_o` both high in the following cycle.
- `ch_req_o` and `ch_config_en_o` drop in the same cycle `wbs_ack_o` rises.
- `ch_addr_o`, `ch_wdata_o`, `ch_wmask_o` and `ch_we_o` are stable from WAIT entry until the next accepted request.

## Test plan
- Write 0x1234_5678, sel 4'hF, to 0x3000_0104 with channel 1 acking immediately:
  - `ch_req_o`=4'b0010, `ch_addr_o`=8'h04, `ch_wmask_o`=4'hF, `ch_config_en_o`=0.
  - `wbs_ack_o` high exactly 2 cycles after stb.
- Read 0x3000_0300 with channel 3 acking after 5 wait cycles and returning 0xCAFE_F00D:
  - `wbs_dat_o`=0xCAFE_F00D with `wbs_ack_o`, cycle 7.
  - `ch_wmask_o`=0.
- Write to 0x3000_0200 (OPCODE_OFFSET) with sel 4'h3: `ch_config_en_o`=4'b0100 coincident with `ch_req_o`; `ch_wmask_o`=4'h3.
- Read 0x3000_0400 and 0x2FFF_FFFC (misses): no `ch_req_o`, `wbs_ack_o` in cycle 1, `wbs_dat_o`=0.
- Read channel 0 with no backend ack, TIMEOUT=255: `timeout_o` and `wbs_ack_o` in cycle 256, `wbs_dat_o`=0.
- Abort and reset:
  - Drop `wbs_cyc_i` in cycle 3 of a waiting transfer: no `wbs_ack_o`, IDLE next cycle; a late `ch_ack_i` is ignored.
  - Separately, assert `wb_rst_i` mid-WAIT: all outputs 0 immediately, without waiting for a clock edge.
